// File: rtl/eq_band_mix_seq_pkg.sv
// Shared constants, FSM state encoding and the band-select helper for the band mixer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package eq_pkg;

  localparam int          SAMPLE_W  = 16;
  localparam int          MAX_BANDS = 16;
  localparam logic [15:0] SAT_POS   = 16'h7FFF;
  localparam logic [15:0] SAT_NEG   = 16'h8000;

  // FSM state encoding
  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ACCUM = 2'd1;
  localparam logic [1:0] OUT   = 2'd2;

  // Pick sample idx out of a bus padded to MAX_BANDS samples.
  function automatic logic [SAMPLE_W-1:0] band_sel(
    input logic [MAX_BANDS*SAMPLE_W-1:0] bus,
    input logic [4:0]                    idx
  );
    logic [SAMPLE_W-1:0] r;
    r = '0;
    for (int k = 0; k < MAX_BANDS; k++) begin
      if (idx == 5'(k)) r = bus[k*SAMPLE_W +: SAMPLE_W];
    end
    return r;
  endfunction

endpackage

// File: rtl/eq_band_mix_seq_if.sv
// Band-vector input and mixed-sample output handshakes of the band mixer.
// Latency: n/a (wires only).
// Backpressure: in_valid/in_ready on the input side, out_valid/out_ready on the output side.
// Ports: in_valid, in_ready, bands_i, band_en_i, out_valid, out_ready, out_data, out_sat.
interface eq_band_mix_seq_if #(
  parameter int N_BANDS = 4
);
  logic                  in_valid;
  logic                  in_ready;
  logic [N_BANDS*16-1:0] bands_i;
  logic [N_BANDS-1:0]    band_en_i;
  logic                  out_valid;
  logic                  out_ready;
  logic [15:0]           out_data;
  logic                  out_sat;

  modport master (
    output in_valid, bands_i, band_en_i, out_ready,
    input  in_ready, out_valid, out_data, out_sat
  );

  modport slave (
    input  in_valid, bands_i, band_en_i, out_ready,
    output in_ready, out_valid, out_data, out_sat
  );
endinterface

// File: rtl/eq_band_mix_seq_sum.sv
// Sum: 16-bit signed saturating adder, clamps to 0x7FFF / 0x8000 on overflow.
// Latency: combinational.
// Backpressure: none.
// Ports: A, B operands (Q1.15), Y saturated result.
module Sum
  import eq_pkg::*;
(
  input  logic [SAMPLE_W-1:0] A,
  input  logic [SAMPLE_W-1:0] B,
  output logic [SAMPLE_W-1:0] Y
);
  logic [SAMPLE_W-1:0] raw;
  logic                ovf;

  always_comb begin
    raw = A + B;
    // Overflow only when operands share a sign and the wrapped result flips it.
    ovf = (A[SAMPLE_W-1] == B[SAMPLE_W-1]) && (raw[SAMPLE_W-1] != A[SAMPLE_W-1]);
    Y   = ovf ? (A[SAMPLE_W-1] ? SAT_NEG : SAT_POS) : raw;
  end
endmodule

// File: rtl/eq_band_mix_seq.sv
// Time-multiplexed band mixer: sums N_BANDS samples through one shared saturating adder.
// Latency: accept in cycle 0, out_valid first high in cycle N_BANDS; one sample per N_BANDS+1 cycles.
// Backpressure: in_ready only in IDLE; result held stable in OUT until out_ready.
// Ports: clk, rst_n (sync, active low), io (slave side of eq_band_mix_seq_if).
module eq_band_mix_seq
  import eq_pkg::*;
#(
  parameter int N_BANDS = 4,
  parameter int W       = SAMPLE_W
) (
  input  logic                   clk,
  input  logic                   rst_n,
  eq_band_mix_seq_if.slave       io
);
  localparam int             IW    = $clog2(N_BANDS) + 1;
  localparam logic [IW-1:0]  LAST  = IW'(N_BANDS - 1);
  // With a single band nothing is left to add after the accept, so idx stays 0.
  localparam logic [IW-1:0]  FIRST = (N_BANDS > 1) ? IW'(1) : '0;

  logic [1:0]               state_q, state_d;
  logic [N_BANDS*W-1:0]     bands_q;
  logic [N_BANDS-1:0]       en_q;
  logic [W-1:0]             acc_q;
  logic                     sat_q;
  logic [IW-1:0]            idx_q;

  logic [MAX_BANDS*W-1:0]   bus_ext;
  logic [MAX_BANDS-1:0]     en_ext;
  logic [4:0]               idx_ext;
  logic [W-1:0]             addend;
  logic [W-1:0]             sum_y;
  logic [W-1:0]             raw;
  logic                     ovf;

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (io.in_valid) state_d = (N_BANDS == 1) ? OUT : ACCUM;
      ACCUM:   if (idx_q == LAST) state_d = OUT;
      OUT:     if (io.out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs: handshakes decode the state, data comes straight from the accumulator.
  always_comb begin
    io.in_ready  = (state_q == IDLE);
    io.out_valid = (state_q == OUT);
    io.out_data  = acc_q;
    io.out_sat   = sat_q;
  end

  // Addend for the current band; buses are zero-padded so the shared helper can index them.
  always_comb begin
    bus_ext                 = '0;
    bus_ext[N_BANDS*W-1:0]  = bands_q;
    en_ext                  = '0;
    en_ext[N_BANDS-1:0]     = en_q;
    idx_ext                 = '0;
    idx_ext[IW-1:0]         = idx_q;
    addend = en_ext[idx_ext[3:0]] ? band_sel(bus_ext, idx_ext) : '0;
    // Overflow flag recomputed here from operand and wrapped-result signs.
    raw    = acc_q + addend;
    ovf    = (acc_q[W-1] == addend[W-1]) && (raw[W-1] != acc_q[W-1]);
  end

  Sum u_sum (
    .A (acc_q),
    .B (addend),
    .Y (sum_y)
  );

  // Datapath
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bands_q <= '0;
      en_q    <= '0;
      acc_q   <= '0;
      sat_q   <= 1'b0;
      idx_q   <= '0;
    end else begin
      case (state_q)
        IDLE: if (io.in_valid) begin
          bands_q <= io.bands_i;
          en_q    <= io.band_en_i;
          acc_q   <= io.band_en_i[0] ? io.bands_i[W-1:0] : '0;
          sat_q   <= 1'b0;
          idx_q   <= FIRST;
        end
        ACCUM: begin
          acc_q <= sum_y;
          sat_q <= sat_q | ovf;
          // Park on the last band so idx never runs past N_BANDS-1.
          if (idx_q != LAST) idx_q <= idx_q + 1'b1;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_eq_band_mix_seq.sv
module tb_eq_band_mix_seq;
  import eq_pkg::*;

  localparam int NB = 4;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;

  eq_band_mix_seq_if #(.N_BANDS(NB)) bif ();

  eq_band_mix_seq #(.N_BANDS(NB), .W(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .io    (bif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] bands;
    logic [3:0]  en;
    logic [15:0] exp_d;
    logic        exp_s;
    int          hold;
  } vec_t;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h", nm, act, exp);
    end
  endtask

  // Reference: exact integer running sum, clamped to the Q1.15 range after each band.
  function automatic logic [16:0] ref_mix(input logic [63:0] b, input logic [3:0] en);
    int s;
    bit sat;
    logic [15:0] smp;
    s = 0;
    sat = 0;
    for (int k = 0; k < NB; k++) begin
      smp = b[k*16 +: 16];
      if (en[k]) s = s + int'($signed(smp));
      if (s > 32767)  begin s = 32767;  sat = 1; end
      if (s < -32768) begin s = -32768; sat = 1; end
    end
    return {sat, s[15:0]};
  endfunction

  // One full transaction: accept, latency, optional stall in OUT, handshake.
  task automatic run_vec(input logic [63:0] b, input logic [3:0] en, input logic [15:0] ed,
                         input logic es, input int hold, input string nm);
    int lat;
    lat = 0;
    while (!bif.in_ready && lat < 20) begin @(posedge clk); #1; lat++; end
    chk({nm, " in_ready before accept"}, 32'(bif.in_ready), 1);
    bif.bands_i   = b;
    bif.band_en_i = en;
    bif.in_valid  = 1'b1;
    bif.out_ready = (hold == 0);
    @(posedge clk); #1;
    bif.in_valid  = 1'b0;
    bif.bands_i   = {$urandom, $urandom};
    bif.band_en_i = 4'($urandom);
    lat = 1;
    while (!bif.out_valid && lat < 20) begin @(posedge clk); #1; lat++; end
    chk({nm, " latency"}, lat, NB);
    chk({nm, " out_data"}, 32'(bif.out_data), 32'(ed));
    chk({nm, " out_sat"}, 32'(bif.out_sat), 32'(es));
    for (int h = 0; h < hold; h++) begin
      chk({nm, " stall out_valid"}, 32'(bif.out_valid), 1);
      chk({nm, " stall in_ready"}, 32'(bif.in_ready), 0);
      chk({nm, " stall out_data"}, 32'(bif.out_data), 32'(ed));
      chk({nm, " stall out_sat"}, 32'(bif.out_sat), 32'(es));
      @(posedge clk); #1;
    end
    bif.out_ready = 1'b1;
    @(posedge clk); #1;
    chk({nm, " out_valid after handshake"}, 32'(bif.out_valid), 0);
    chk({nm, " in_ready after handshake"}, 32'(bif.in_ready), 1);
  endtask

  vec_t vt[5];

  initial begin
    logic [63:0] rb;
    logic [3:0]  ren;
    logic [16:0] rexp;
    bit          saw_valid;

    total = 0;
    bad   = 0;
    rst_n = 1'b0;
    bif.in_valid  = 1'b0;
    bif.out_ready = 1'b1;
    bif.bands_i   = '0;
    bif.band_en_i = '0;

    vt[0] = '{64'h0001_0010_0100_1000, 4'b1111, 16'h1111, 1'b0, 0};
    vt[1] = '{64'h0000_0000_8000_8000, 4'b1111, 16'h8000, 1'b1, 0};
    vt[2] = '{64'h0000_9000_7000_7000, 4'b1111, 16'h0FFF, 1'b1, 0};
    vt[3] = '{64'h4000_0300_2000_1000, 4'b0101, 16'h1300, 1'b0, 0};
    vt[4] = '{64'h0001_0010_0100_1000, 4'b1111, 16'h1111, 1'b0, 3};

    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    chk("reset in_ready", 32'(bif.in_ready), 1);
    chk("reset out_valid", 32'(bif.out_valid), 0);
    chk("reset out_data", 32'(bif.out_data), 0);
    chk("reset out_sat", 32'(bif.out_sat), 0);

    for (int i = 0; i < 5; i++) begin
      run_vec(vt[i].bands, vt[i].en, vt[i].exp_d, vt[i].exp_s, vt[i].hold,
              $sformatf("vec%0d", i));
    end

    // Back-to-back accept right after a stalled handshake (in_ready already checked).
    run_vec(64'h0004_0003_0002_0001, 4'b1111, 16'h000A, 1'b0, 0, "after_stall");

    // Reset during ACCUM (cycle 2) aborts the sample.
    bif.bands_i   = 64'h1000_1000_1000_1000;
    bif.band_en_i = 4'b1111;
    bif.in_valid  = 1'b1;
    @(posedge clk); #1;
    bif.in_valid  = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    chk("midrst in_ready", 32'(bif.in_ready), 1);
    chk("midrst out_valid", 32'(bif.out_valid), 0);
    chk("midrst out_data", 32'(bif.out_data), 0);
    chk("midrst out_sat", 32'(bif.out_sat), 0);
    rst_n = 1'b1;
    saw_valid = 0;
    for (int c = 0; c < 8; c++) begin
      @(posedge clk); #1;
      if (bif.out_valid) saw_valid = 1;
    end
    chk("midrst no out_valid pulse", 32'(saw_valid), 0);

    // Randomized vectors against the reference.
    for (int i = 0; i < 60; i++) begin
      rb = {$urandom, $urandom};
      if (i % 3 == 0) begin
        for (int k = 0; k < NB; k++) rb[k*16+14 -: 2] = {rb[k*16+15], rb[k*16+15]};
      end
      ren  = 4'($urandom_range(0, 15));
      rexp = ref_mix(rb, ren);
      run_vec(rb, ren, rexp[15:0], rexp[16], $urandom_range(0, 2), $sformatf("rnd%0d", i));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
